sync_fifo_reader: RTL and testbench
===================================

SYNC_FIFO_READER -- requirements
Module: sync_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of FIFO read data and stream data.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, width of the transfer counter.
REQ-003 SHALL use one clock and an asynchronous, active-low reset; the ports are clk_i and rst_n_i.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n_i  input  1  asynchronous active-low reset.
REQ-006 enable_i  input  1  permits issuing new FIFO reads when high.
REQ-007 fifo_empty_i  input  1  empty flag of the attached standard (non-FWFT) synchronous FIFO.
REQ-008 fifo_rd_data_i  input  DATA_WIDTH  FIFO read port; valid exactly one cycle after a read is issued.
REQ-009 fifo_read_o  output  1  read strobe to the FIFO.
REQ-010 m_valid_o  output  1  output stream data valid.
REQ-011 m_ready_i  input  1  output stream sink ready.
REQ-012 m_data_o  output  DATA_WIDTH  output stream data.
REQ-013 words_o  output  CNT_WIDTH  count of completed output transfers.

Function
REQ-014 SHALL drain the FIFO into a valid/ready stream at a sustained rate of 1 word/cycle when the FIFO is non-empty and m_ready_i is held high.
REQ-015 SHALL hold a 2-entry skid buffer (head, tail) with occupancy state EMPTY (0), ONE (1) or TWO (2).
REQ-016 SHALL keep a registered in-flight flag, set in the cycle after fifo_read_o is high and cleared otherwise.
REQ-017 SHALL capture fifo_rd_data_i into the buffer in every cycle the in-flight flag is high, unconditionally.
REQ-018 pop = m_valid_o AND m_ready_i; a transfer completes on a rising edge with pop high.
REQ-019 fifo_read_o = rst_n_i AND enable_i AND NOT fifo_empty_i AND (occupancy + in-flight - pop < 2), combinational.
REQ-020 SHALL never let occupancy + in-flight exceed 2; an arrival into a full buffer is impossible by construction.
REQ-021 m_valid_o SHALL be high iff occupancy is not EMPTY; m_data_o SHALL always be the head entry.
REQ-022 State transitions, with arrival = in-flight flag:
 - EMPTY: arrival -> ONE, head = data.
 - ONE: arrival & pop -> ONE, head = data; arrival & !pop -> TWO, tail = data; !arrival & pop -> EMPTY.
 - TWO: pop -> ONE, head = tail; !pop -> TWO.
REQ-023 SHALL keep m_data_o and m_valid_o stable while m_valid_o is high and m_ready_i is low.
REQ-024 Latency SHALL be: fifo_read_o at cycle N -> m_valid_o high with that word at cycle N+2 when the buffer was EMPTY.
REQ-025 words_o SHALL increment by 1 on each pop and wrap modulo 2^CNT_WIDTH.
REQ-026 enable_i low SHALL block new reads only; in-flight and buffered words SHALL still be delivered in order.
REQ-027 Word order on m_data_o SHALL equal FIFO read order, with no drops or duplicates.

Reset
REQ-028 On rst_n_i low: occupancy EMPTY, in-flight 0, m_valid_o 0, m_data_o 0, words_o 0, fifo_read_o 0, all immediately and without a clock edge.
REQ-029 Reset mid-operation SHALL discard buffered and in-flight words; no word SHALL be output after reset release until a new read completes.
REQ-030 The first fifo_read_o SHALL be possible in the first cycle after rst_n_i rises.

Verification
REQ-031 Streaming: FIFO preloaded with 0x1..0x8, enable_i=1, m_ready_i=1 -> m_data_o = 0x1..0x8 on 8 consecutive cycles starting 2 cycles after the first read; words_o=8.
REQ-032 Backpressure: m_ready_i=0 with 4 words queued -> exactly 2 reads issued, m_valid_o=1, m_data_o=0x1 held; on m_ready_i=1 -> 0x1..0x4 delivered in order.
REQ-033 Empty stall: FIFO holds 1 word (0xA5) -> one read, 0xA5 delivered, then m_valid_o=0 and fifo_read_o=0 while fifo_empty_i=1.
REQ-034 Enable drop: enable_i lowered in the cycle after a read -> that word is still delivered, no further fifo_read_o.
REQ-035 Async reset: rst_n_i pulsed low between clock edges while in state TWO -> m_valid_o=0 and words_o=0 immediately; the stale words are never output.
REQ-036 Counter wrap: CNT_WIDTH=4, 17 transfers -> words_o=1.

Source files
------------

// File: rtl/sync_fifo_reader.sv
// sync_fifo_reader
// Drains a standard (non-FWFT) synchronous FIFO into a valid/ready stream.
// A FIFO read returns its word one cycle later, so a two-entry skid buffer
// (head/tail) plus a registered in-flight flag keep 1 word/cycle throughput
// under a held-high sink. The buffer can never overflow, because a read is
// issued only when occupancy + in-flight - pop stays below two.

module sync_fifo_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  fifo_read_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [CNT_WIDTH-1:0]  words_o
);

    // Skid-buffer occupancy encoding
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    logic [1:0]            occ_q;
    logic [1:0]            occ_d;
    logic                  inflight_q;
    logic                  inflight_d;
    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] head_d;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [DATA_WIDTH-1:0] tail_d;
    logic [CNT_WIDTH-1:0]  words_q;
    logic [CNT_WIDTH-1:0]  words_d;

    logic                  pop_s;
    logic                  arrival_s;
    logic [2:0]            fill_s;
    logic                  room_s;

    // Head is always presented; valid follows occupancy directly
    assign m_valid_o = (occ_q != ST_EMPTY);
    assign m_data_o  = head_q;
    assign words_o   = words_q;
    assign pop_s     = m_valid_o & m_ready_i;
    assign arrival_s = inflight_q;

    // Projected fill after this cycle's pop; a new read is allowed only while it stays below two
    always_comb begin
        fill_s = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop_s};
        if (fill_s < 3'd2) begin
            room_s = 1'b1;
        end else begin
            room_s = 1'b0;
        end
    end

    // Read strobe is combinational and forced low while reset is asserted
    always_comb begin
        fifo_read_o = 1'b0;
        if (rst_n_i && enable_i && !fifo_empty_i && room_s) begin
            fifo_read_o = 1'b1;
        end else begin
            fifo_read_o = 1'b0;
        end
    end

    // Skid-buffer next state: the word returned by an in-flight read is always captured
    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = fifo_read_o;
        case (occ_q)
            ST_EMPTY: begin
                if (arrival_s) begin
                    occ_d  = ST_ONE;
                    head_d = fifo_rd_data_i;
                end else begin
                    occ_d  = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (arrival_s && pop_s) begin
                    occ_d  = ST_ONE;
                    head_d = fifo_rd_data_i;
                end else if (arrival_s) begin
                    occ_d  = ST_TWO;
                    tail_d = fifo_rd_data_i;
                end else if (pop_s) begin
                    occ_d  = ST_EMPTY;
                end else begin
                    occ_d  = ST_ONE;
                end
            end
            ST_TWO: begin
                if (pop_s) begin
                    occ_d  = ST_ONE;
                    head_d = tail_q;
                end else begin
                    occ_d  = ST_TWO;
                end
            end
            default: begin
                // Unreachable encoding: fall back to an empty buffer
                occ_d  = ST_EMPTY;
            end
        endcase
    end

    // Transfer counter advances once per completed handshake and wraps naturally
    always_comb begin
        words_d = words_q;
        if (pop_s) begin
            words_d = words_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            words_d = words_q;
        end
    end

    // State registers; reset discards buffered and in-flight words immediately
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            occ_q      <= ST_EMPTY;
            inflight_q <= 1'b0;
            head_q     <= {DATA_WIDTH{1'b0}};
            tail_q     <= {DATA_WIDTH{1'b0}};
            words_q    <= {CNT_WIDTH{1'b0}};
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            words_q    <= words_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Bench for sync_fifo_reader: a behavioural non-FWFT FIFO feeds the DUT,
// stimulus pushes expected words and point checks into queues, and a single
// monitor process on the falling clock edge (and on reset assertion) compares.

module tb_sync_fifo_reader;

    localparam int DW = 32;
    localparam int CW = 4;

    localparam int K_VALID = 0;
    localparam int K_READ  = 1;
    localparam int K_DATA  = 2;
    localparam int K_WORDS = 3;
    localparam int K_RDPTR = 4;
    localparam int K_PEND  = 5;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } rec_t;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_read;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] words;

    logic [DW-1:0] mem [0:255];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    logic [DW-1:0] exp_q [$];
    rec_t          chk_q [$];

    int            checks = 0;
    int            errors = 0;
    int            exp_words = 0;
    bit            hold = 1'b0;
    logic [DW-1:0] hold_data = '0;

    sync_fifo_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .enable_i       (enable),
        .fifo_empty_i   (fifo_empty),
        .fifo_rd_data_i (fifo_rd_data),
        .fifo_read_o    (fifo_read),
        .m_valid_o      (m_valid),
        .m_ready_i      (m_ready),
        .m_data_o       (m_data),
        .words_o        (words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural standard FIFO: data appears one cycle after the read strobe
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (fifo_read) begin
            fifo_rd_data <= mem[rd_ptr[7:0]];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h required %h", name, $time, act, req);
        end
    endtask

    task automatic run_records();
        rec_t r;
        while (chk_q.size() > 0) begin
            r = chk_q.pop_front();
            case (r.kind)
                K_VALID: chk("m_valid", {31'd0, m_valid}, r.val);
                K_READ:  chk("fifo_read", {31'd0, fifo_read}, r.val);
                K_DATA:  chk("m_data", m_data, r.val);
                K_WORDS: chk("words_rec", {28'd0, words}, r.val);
                K_RDPTR: chk("fifo_reads_total", 32'(rd_ptr), r.val);
                K_PEND:  chk("pending_words", 32'(exp_q.size()), r.val);
                default: begin end
            endcase
        end
    endtask

    // Monitor: reset values, handshake scoreboard, hold stability, counter model, point checks
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            exp_words = 0;
            hold      = 1'b0;
            chk("rst_valid", {31'd0, m_valid}, 32'd0);
            chk("rst_words", {28'd0, words}, 32'd0);
            chk("rst_read", {31'd0, fifo_read}, 32'd0);
            chk("rst_data", m_data, 32'd0);
            run_records();
        end else begin
            if (hold) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", m_data, hold_data);
            end
            chk("words", {28'd0, words}, 32'(exp_words));
            if (fifo_read) begin
                chk("read_when_empty", {31'd0, fifo_empty}, 32'd0);
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_xfer at %0t: got word %h required no transfer", $time, m_data);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL stream_word at %0t: got %h required %h", $time, m_data, e);
                    end
                end
                exp_words = (exp_words + 1) % 16;
            end
            run_records();
            hold      = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rec(input int kind, input logic [31:0] val);
        rec_t r;
        r.kind = kind;
        r.val  = val;
        chk_q.push_back(r);
    endtask

    task automatic load(input logic [31:0] w, input bit deliver);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
        if (deliver) begin
            exp_q.push_back(w);
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        m_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        // Streaming: eight words back to back, first valid two cycles after first read
        for (int i = 1; i <= 8; i++) load(32'(i), 1'b1);
        enable  = 1'b1;
        m_ready = 1'b1;
        expect_rec(K_READ, 32'd1);
        expect_rec(K_VALID, 32'd0);
        tick();
        expect_rec(K_VALID, 32'd0);
        tick();
        for (int i = 0; i < 8; i++) begin
            expect_rec(K_VALID, 32'd1);
            tick();
        end
        expect_rec(K_VALID, 32'd0);
        expect_rec(K_READ, 32'd0);
        expect_rec(K_WORDS, 32'd8);
        expect_rec(K_RDPTR, 32'd8);
        tick();

        // Backpressure: only two reads while the sink stalls, head held
        enable  = 1'b0;
        m_ready = 1'b0;
        pulse_reset();
        for (int i = 1; i <= 4; i++) load(32'(i), 1'b1);
        enable = 1'b1;
        expect_rec(K_READ, 32'd1);
        tick();
        expect_rec(K_READ, 32'd1);
        expect_rec(K_VALID, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_rec(K_READ, 32'd0);
            expect_rec(K_VALID, 32'd1);
            expect_rec(K_DATA, 32'h1);
            tick();
        end
        expect_rec(K_RDPTR, 32'd10);
        m_ready = 1'b1;
        repeat (6) tick();
        expect_rec(K_VALID, 32'd0);
        expect_rec(K_WORDS, 32'd4);
        expect_rec(K_RDPTR, 32'd12);
        tick();

        // Empty stall: single word, then idle with no further reads
        enable = 1'b0;
        pulse_reset();
        load(32'hA5, 1'b1);
        enable = 1'b1;
        expect_rec(K_READ, 32'd1);
        tick();
        expect_rec(K_READ, 32'd0);
        expect_rec(K_VALID, 32'd0);
        tick();
        expect_rec(K_VALID, 32'd1);
        expect_rec(K_DATA, 32'hA5);
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_rec(K_VALID, 32'd0);
            expect_rec(K_READ, 32'd0);
            tick();
        end
        expect_rec(K_WORDS, 32'd1);
        expect_rec(K_RDPTR, 32'd13);
        tick();

        // Enable drop right after a read: that word still arrives, nothing more is read
        enable = 1'b0;
        pulse_reset();
        load(32'h5A, 1'b1);
        load(32'h5B, 1'b0);
        enable = 1'b1;
        expect_rec(K_READ, 32'd1);
        tick();
        enable = 1'b0;
        expect_rec(K_READ, 32'd0);
        expect_rec(K_VALID, 32'd0);
        tick();
        expect_rec(K_VALID, 32'd1);
        expect_rec(K_DATA, 32'h5A);
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_rec(K_VALID, 32'd0);
            expect_rec(K_READ, 32'd0);
            tick();
        end
        expect_rec(K_RDPTR, 32'd14);
        expect_rec(K_WORDS, 32'd1);
        tick();

        // Async reset while the buffer holds two words: stale words never appear
        m_ready = 1'b0;
        load(32'hB2, 1'b0);
        enable = 1'b1;
        expect_rec(K_READ, 32'd1);
        tick();
        expect_rec(K_READ, 32'd1);
        tick();
        expect_rec(K_READ, 32'd0);
        expect_rec(K_VALID, 32'd1);
        tick();
        expect_rec(K_VALID, 32'd1);
        expect_rec(K_DATA, 32'h5B);
        expect_rec(K_RDPTR, 32'd16);
        expect_rec(K_WORDS, 32'd1);
        tick();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        m_ready = 1'b1;
        expect_rec(K_VALID, 32'd0);
        expect_rec(K_WORDS, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            expect_rec(K_VALID, 32'd0);
            expect_rec(K_READ, 32'd0);
            tick();
        end
        load(32'hC3, 1'b1);
        expect_rec(K_READ, 32'd1);
        tick();
        expect_rec(K_VALID, 32'd0);
        tick();
        expect_rec(K_VALID, 32'd1);
        expect_rec(K_DATA, 32'hC3);
        tick();
        expect_rec(K_VALID, 32'd0);
        expect_rec(K_WORDS, 32'd1);
        expect_rec(K_RDPTR, 32'd17);
        tick();

        // Counter wrap with a 4-bit counter; first read right after reset release
        rst_n = 1'b0;
        for (int i = 0; i < 17; i++) load(32'h100 + 32'(i), 1'b1);
        enable  = 1'b1;
        m_ready = 1'b1;
        expect_rec(K_READ, 32'd0);
        tick();
        expect_rec(K_READ, 32'd0);
        tick();
        rst_n = 1'b1;
        expect_rec(K_READ, 32'd1);
        expect_rec(K_VALID, 32'd0);
        tick();
        expect_rec(K_VALID, 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            expect_rec(K_VALID, 32'd1);
            tick();
        end
        expect_rec(K_WORDS, 32'd0);
        expect_rec(K_VALID, 32'd1);
        expect_rec(K_DATA, 32'h110);
        tick();
        expect_rec(K_VALID, 32'd0);
        expect_rec(K_WORDS, 32'd1);
        expect_rec(K_RDPTR, 32'd34);
        tick();

        expect_rec(K_PEND, 32'd0);
        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
